carry_select_adder_8b: RTL and testbench

- 8-bit carry-select adder with registered outputs.
- Computes {cout, s} = a + b + cin. The low nibble uses a ripple-carry chain. The high nibble is precomputed twice, once for carry-in 0 and once for carry-in 1, and the low-nibble carry-out selects between them.
- Used as a single-cycle-latency arithmetic leaf in datapaths clocked by the system clock.

---
 rtl/carry_select_adder_8b.sv | 100 ++++++++++
 tb/tb_carry_select_adder_8b.sv | 103 ++++++++++
 2 files changed

// File: rtl/carry_select_adder_8b.sv
// 8-bit carry-select adder with registered sum and carry-out.
// The low nibble ripples from cin. The high nibble is computed for both carry-in values, and c4 picks one.

module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = x ^ y ^ ci;
  assign co  = (x & y) | (ci & (x ^ y));

endmodule

module rca4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] sum,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    full_adder u_fa (
      .x   (x[i]),
      .y   (y[i]),
      .ci  (c[i]),
      .sum (sum[i]),
      .co  (c[i+1])
    );
  end

  assign co = c[4];

endmodule

module carry_select_adder_8b (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic [3:0] s_lo;
  logic       c4;
  logic [3:0] sum0;
  logic [3:0] sum1;
  logic       c8_0;
  logic       c8_1;
  logic [7:0] s_next;
  logic       cout_next;

  rca4 u_lo (
    .x   (a[3:0]),
    .y   (b[3:0]),
    .ci  (cin),
    .sum (s_lo),
    .co  (c4)
  );

  // Both high-nibble candidates are built in parallel, so c4 only has to drive the select mux.
  rca4 u_hi0 (
    .x   (a[7:4]),
    .y   (b[7:4]),
    .ci  (1'b0),
    .sum (sum0),
    .co  (c8_0)
  );

  rca4 u_hi1 (
    .x   (a[7:4]),
    .y   (b[7:4]),
    .ci  (1'b1),
    .sum (sum1),
    .co  (c8_1)
  );

  assign s_next    = {(c4 ? sum1 : sum0), s_lo};
  assign cout_next = c4 ? c8_1 : c8_0;

  always_ff @(posedge clk) begin
    if (rst) begin
      s    <= 8'h00;
      cout <= 1'b0;
    end else begin
      s    <= s_next;
      cout <= cout_next;
    end
  end

endmodule

// File: tb/tb_carry_select_adder_8b.sv
// Directed and random checks of carry_select_adder_8b: reset, block-boundary carries, one-cycle latency.
module tb_carry_select_adder_8b;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] s;
  logic       cout;

  int vecCount  = 0;
  int missCount = 0;

  carry_select_adder_8b dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .s    (s),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input logic cv, input logic rv);
    a   = av;
    b   = bv;
    cin = cv;
    rst = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [8:0] observed,
                             input logic [8:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got {cout,s}=%h, expected %h", tag, observed, expected);
    end
  endtask

  // Each directed entry holds a, b, cin and the hand-computed {cout,s}.
  logic [7:0] vecA [6] = '{8'h00, 8'h05, 8'h0F, 8'hA5, 8'hFF, 8'hAA};
  logic [7:0] vecB [6] = '{8'h00, 8'h03, 8'h01, 8'h5A, 8'hFF, 8'h55};
  logic       vecC [6] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
  logic [8:0] vecE [6] = '{9'h000, 9'h008, 9'h010, 9'h100, 9'h1FF, 9'h0FF};

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] expSum;

    a = 8'hFF; b = 8'hFF; cin = 1'b1; rst = 1'b1;

    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b1);
    checkOutput("reset0", {cout, s}, 9'h000);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b1);
    checkOutput("reset1", {cout, s}, 9'h000);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);
    checkOutput("release", {cout, s}, 9'h1FF);

    // These vectors run back to back, one result per edge.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecA[i], vecB[i], vecC[i], 1'b0);
      checkOutput($sformatf("dir%0d", i), {cout, s}, vecE[i]);
    end

    // A change on the inputs between edges must not reach the outputs.
    a = 8'h01; b = 8'h01; cin = 1'b1;
    #2;
    checkOutput("noComb", {cout, s}, 9'h0FF);

    applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0);
    checkOutput("preRst", {cout, s}, 9'h010);
    applyStimulus(8'hA5, 8'h5A, 1'b1, 1'b1);
    checkOutput("midRst", {cout, s}, 9'h000);
    applyStimulus(8'h05, 8'h03, 1'b0, 1'b0);
    checkOutput("postRst", {cout, s}, 9'h008);
    applyStimulus(8'h80, 8'h80, 1'b0, 1'b0);
    checkOutput("hiCarry", {cout, s}, 9'h100);
    applyStimulus(8'h08, 8'h08, 1'b1, 1'b0);
    checkOutput("loCarry", {cout, s}, 9'h011);

    for (int i = 0; i < 10000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      expSum = 9'(ra) + 9'(rb) + 9'(rc);
      applyStimulus(ra, rb, rc, 1'b0);
      checkOutput($sformatf("rand%0d", i), {cout, s}, expSum);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
